// File: rtl/ram_arb_pkg.sv
// Shared types and default widths for the instruction/data RAM arbiter.
package ram_arb_pkg;

  localparam int unsigned DEF_ADDR_W = 11;
  localparam int unsigned DEF_DATA_W = 32;

  // Arbiter FSM: either free to grant, or waiting for read data.
  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } arb_state_e;

  // Requester identity, used both for the grant and for the read owner.
  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_D  = 1'b1
  } req_e;

endpackage

// File: rtl/ram_arbiter.sv
// Two-requester RAM arbiter: instruction fetch (IF) and load/store data (D).
// D has priority; a starvation counter forces an IF grant after STARVE_MAX
// consecutive D grants with a fetch pending. Reads wait RD_LAT cycles for
// ram_rdata, stores complete in the grant cycle.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  // Instruction fetch requester
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  // Load/store requester
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  // RAM side
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);

  localparam int unsigned         STREAK_W   = $clog2(STARVE_MAX + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_MAX);
  localparam logic [1:0]          LAT_INIT   = 2'(RD_LAT - 1);

  arb_state_e          state_q, state_d;
  logic [1:0]          lat_q, lat_d;
  req_e                owner_q, owner_d;
  logic [STREAK_W-1:0] streak_q, streak_d;

  // D wins unless a fetch is pending and has already been passed over
  // STARVE_MAX times in a row.
  function automatic req_e arbitrate(input logic                if_pend,
                                     input logic                d_pend,
                                     input logic [STREAK_W-1:0] streak);
    if (d_pend && !(if_pend && streak == STREAK_MAX)) return REQ_D;
    return REQ_IF;
  endfunction

  // State, latency counter, read owner and starvation streak registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; reset is asynchronous and drops any read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      lat_q    <= 2'd0;
      owner_q  <= REQ_IF;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      lat_q    <= lat_d;
      owner_q  <= owner_d;
      streak_q <= streak_d;
    end
  end

  // Arbitration, RAM command generation, read-data return and next state.
  // Every output is held at 0 while rst_n is low, including combinational acks.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_d   = state_q;
    lat_d     = lat_q;
    owner_d   = owner_q;
    streak_d  = streak_q;
    ram_addr  = '0;
    ram_wdata = '0;
    ram_wren  = 1'b0;
    if_ack    = 1'b0;
    d_ack     = 1'b0;
    if_rvalid = 1'b0;
    d_rvalid  = 1'b0;
    if_rdata  = '0;
    d_rdata   = '0;
    busy      = 1'b0;

    if (rst_n) begin
      case (state_q)
        IDLE: begin
          if (d_req || if_req) begin
            if (arbitrate(if_req, d_req, streak_q) == REQ_D) begin
              d_ack    = 1'b1;
              ram_addr = d_addr;
              streak_d = if_req ? streak_q + 1'b1 : '0;
              if (d_we) begin
                // Stores finish at the grant; stay in IDLE for back-to-back.
                ram_wren  = 1'b1;
                ram_wdata = d_wdata;
              end else begin
                state_d = RD_WAIT;
                lat_d   = LAT_INIT;
                owner_d = REQ_D;
              end
            end else begin
              if_ack   = 1'b1;
              ram_addr = if_addr;
              streak_d = '0;
              state_d  = RD_WAIT;
              lat_d    = LAT_INIT;
              owner_d  = REQ_IF;
            end
          end
        end

        RD_WAIT: begin
          busy = 1'b1;
          if (lat_q != 2'd0) begin
            lat_d = lat_q - 2'd1;
          end else begin
            state_d = IDLE;
            if (owner_q == REQ_IF) begin
              if_rvalid = 1'b1;
              if_rdata  = ram_rdata;
            end else begin
              d_rvalid = 1'b1;
              d_rdata  = ram_rdata;
            end
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: three instances with RD_LAT = 1, 2, 3,
// each with its own RAM model, exercised one scenario task at a time.
module tb_ram_arbiter;

  localparam int N = 3;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        if_req    [N];
  logic [10:0] if_addr   [N];
  logic        if_ack    [N];
  logic        if_rvalid [N];
  logic [31:0] if_rdata  [N];
  logic        d_req     [N];
  logic        d_we      [N];
  logic [10:0] d_addr    [N];
  logic [31:0] d_wdata   [N];
  logic        d_ack     [N];
  logic        d_rvalid  [N];
  logic [31:0] d_rdata   [N];
  logic [10:0] ram_addr  [N];
  logic [31:0] ram_wdata [N];
  logic        ram_wren  [N];
  logic [31:0] ram_rdata [N];
  logic        busy      [N];

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // Instance g has RD_LAT = g+1; its RAM returns data g+1 cycles after the address.
  for (genvar g = 0; g < N; g++) begin : g_dut
    logic [31:0] mem  [2048];
    logic [31:0] pipe [3];

    always @(posedge clk) begin
      if (ram_wren[g]) mem[ram_addr[g]] <= ram_wdata[g];
      pipe[0] <= mem[ram_addr[g]];
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
    end

    assign ram_rdata[g] = pipe[g];

    ram_arbiter #(
      .ADDR_W    (11),
      .DATA_W    (32),
      .RD_LAT    (g + 1),
      .STARVE_MAX(4)
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .if_req   (if_req[g]),
      .if_addr  (if_addr[g]),
      .if_ack   (if_ack[g]),
      .if_rvalid(if_rvalid[g]),
      .if_rdata (if_rdata[g]),
      .d_req    (d_req[g]),
      .d_we     (d_we[g]),
      .d_addr   (d_addr[g]),
      .d_wdata  (d_wdata[g]),
      .d_ack    (d_ack[g]),
      .d_rvalid (d_rvalid[g]),
      .d_rdata  (d_rdata[g]),
      .ram_addr (ram_addr[g]),
      .ram_wdata(ram_wdata[g]),
      .ram_wren (ram_wren[g]),
      .ram_rdata(ram_rdata[g]),
      .busy     (busy[g])
    );
  end

  // Outputs are held at 0 during reset even with a request present.
  task automatic test_reset();
    @(negedge clk);
    if_req[0] = 1'b1; if_addr[0] = 11'h005; d_req[1] = 1'b1; d_addr[1] = 11'h00A;
    #1;
    vectors++; if (if_ack[0] !== 1'b0) begin miscompares++; $display("FAIL rst_if_ack: got %b want 0", if_ack[0]); end
    vectors++; if (d_ack[1] !== 1'b0) begin miscompares++; $display("FAIL rst_d_ack: got %b want 0", d_ack[1]); end
    vectors++; if (ram_addr[0] !== 11'h000) begin miscompares++; $display("FAIL rst_ram_addr: got %h want 000", ram_addr[0]); end
    if_req[0] = 1'b0; d_req[1] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    vectors++; if ({busy[0], if_rvalid[0], d_rvalid[0], ram_wren[0]} !== 4'b0000) begin miscompares++; $display("FAIL rst_outputs: got %b want 0000", {busy[0], if_rvalid[0], d_rvalid[0], ram_wren[0]}); end
  endtask

  // Single store through the D port: write at ack, no read response.
  task automatic do_store(input int k, input logic [10:0] a, input logic [31:0] w);
    @(negedge clk);
    d_req[k] = 1'b1; d_we[k] = 1'b1; d_addr[k] = a; d_wdata[k] = w;
    #1;
    vectors++; if (d_ack[k] !== 1'b1) begin miscompares++; $display("FAIL st_ack[%0d]: got %b want 1", k, d_ack[k]); end
    vectors++; if (ram_wren[k] !== 1'b1) begin miscompares++; $display("FAIL st_wren[%0d]: got %b want 1", k, ram_wren[k]); end
    vectors++; if (ram_addr[k] !== a) begin miscompares++; $display("FAIL st_addr[%0d]: got %h want %h", k, ram_addr[k], a); end
    vectors++; if (ram_wdata[k] !== w) begin miscompares++; $display("FAIL st_wdata[%0d]: got %h want %h", k, ram_wdata[k], w); end
    @(negedge clk);
    d_req[k] = 1'b0; d_we[k] = 1'b0;
    #1;
    vectors++; if ({d_rvalid[k], busy[k]} !== 2'b00) begin miscompares++; $display("FAIL st_no_rvalid[%0d]: got %b want 00", k, {d_rvalid[k], busy[k]}); end
  endtask

  // IF read, RD_LAT=1: ack at T, rvalid and busy at T+1, idle at T+2.
  task automatic test_if_read();
    do_store(0, 11'h005, 32'hE3A01001);
    @(negedge clk);
    if_req[0] = 1'b1; if_addr[0] = 11'h005;
    #1;
    vectors++; if (if_ack[0] !== 1'b1) begin miscompares++; $display("FAIL if_ack: got %b want 1", if_ack[0]); end
    vectors++; if (ram_addr[0] !== 11'h005) begin miscompares++; $display("FAIL if_ram_addr: got %h want 005", ram_addr[0]); end
    @(negedge clk);
    if_req[0] = 1'b0;
    #1;
    vectors++; if ({busy[0], if_rvalid[0], if_ack[0]} !== 3'b110) begin miscompares++; $display("FAIL if_wait: got %b want 110", {busy[0], if_rvalid[0], if_ack[0]}); end
    vectors++; if (if_rdata[0] !== 32'hE3A01001) begin miscompares++; $display("FAIL if_rdata: got %h want e3a01001", if_rdata[0]); end
    @(negedge clk);
    #1;
    vectors++; if ({busy[0], if_rvalid[0]} !== 2'b00) begin miscompares++; $display("FAIL if_done: got %b want 00", {busy[0], if_rvalid[0]}); end
    vectors++; if (if_rdata[0] !== 32'h0) begin miscompares++; $display("FAIL if_rdata_idle: got %h want 0", if_rdata[0]); end
  endtask

  // Store then load of the same address returns the stored word.
  task automatic test_store_load();
    do_store(0, 11'h100, 32'hDEADBEEF);
    @(negedge clk);
    d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 11'h100;
    #1;
    vectors++; if ({d_ack[0], ram_wren[0]} !== 2'b10) begin miscompares++; $display("FAIL ld_ack: got %b want 10", {d_ack[0], ram_wren[0]}); end
    @(negedge clk);
    d_req[0] = 1'b0;
    #1;
    vectors++; if (d_rvalid[0] !== 1'b1) begin miscompares++; $display("FAIL ld_rvalid: got %b want 1", d_rvalid[0]); end
    vectors++; if (d_rdata[0] !== 32'hDEADBEEF) begin miscompares++; $display("FAIL ld_rdata: got %h want deadbeef", d_rdata[0]); end
  endtask

  // Two stores on consecutive cycles, then a load of the first.
  task automatic test_back_to_back();
    @(negedge clk);
    d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 11'h200; d_wdata[0] = 32'h11111111;
    #1;
    vectors++; if (d_ack[0] !== 1'b1) begin miscompares++; $display("FAIL b2b_ack0: got %b want 1", d_ack[0]); end
    @(negedge clk);
    d_addr[0] = 11'h201; d_wdata[0] = 32'h22222222;
    #1;
    vectors++; if ({d_ack[0], ram_wren[0], busy[0]} !== 3'b110) begin miscompares++; $display("FAIL b2b_ack1: got %b want 110", {d_ack[0], ram_wren[0], busy[0]}); end
    vectors++; if (ram_wdata[0] !== 32'h22222222) begin miscompares++; $display("FAIL b2b_wdata: got %h want 22222222", ram_wdata[0]); end
    @(negedge clk);
    d_we[0] = 1'b0; d_addr[0] = 11'h200;
    #1;
    vectors++; if ({d_ack[0], ram_wren[0]} !== 2'b10) begin miscompares++; $display("FAIL b2b_ld_ack: got %b want 10", {d_ack[0], ram_wren[0]}); end
    @(negedge clk);
    d_req[0] = 1'b0;
    #1;
    vectors++; if (d_rdata[0] !== 32'h11111111) begin miscompares++; $display("FAIL b2b_rdata: got %h want 11111111", d_rdata[0]); end
  endtask

  // Both requesting: D, D, D, D, then forced IF, then D again (streak cleared).
  task automatic test_contention();
    logic exp_d;
    @(negedge clk);
    if_req[0] = 1'b1; if_addr[0] = 11'h005;
    d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 11'h100;
    for (int i = 0; i < 6; i++) begin
      exp_d = (i != 4);
      #1;
      vectors++; if ({d_ack[0], if_ack[0]} !== {exp_d, ~exp_d}) begin miscompares++; $display("FAIL arb%0d_ack: got d/if %b want %b", i, {d_ack[0], if_ack[0]}, {exp_d, ~exp_d}); end
      @(negedge clk);
      if (i == 5) begin if_req[0] = 1'b0; d_req[0] = 1'b0; end
      #1;
      vectors++; if ({busy[0], d_ack[0], if_ack[0], d_rvalid[0], if_rvalid[0]} !== {3'b100, exp_d, ~exp_d}) begin miscompares++; $display("FAIL arb%0d_wait: got %b want %b", i, {busy[0], d_ack[0], if_ack[0], d_rvalid[0], if_rvalid[0]}, {3'b100, exp_d, ~exp_d}); end
      vectors++; if ((exp_d ? d_rdata[0] : if_rdata[0]) !== (exp_d ? 32'hDEADBEEF : 32'hE3A01001)) begin miscompares++; $display("FAIL arb%0d_rdata: got %h", i, exp_d ? d_rdata[0] : if_rdata[0]); end
      @(negedge clk);
    end
    #1;
    vectors++; if (busy[0] !== 1'b0) begin miscompares++; $display("FAIL arb_end_busy: got %b want 0", busy[0]); end
  endtask

  // No requests for 10 cycles: every output stays 0.
  task automatic test_idle();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      vectors++; if ({ram_wren[0], ram_addr[0], ram_wdata[0], if_ack[0], d_ack[0], if_rvalid[0], d_rvalid[0], busy[0]} !== '0) begin miscompares++; $display("FAIL idle%0d: wren %b addr %h wdata %h acks %b%b rv %b%b busy %b, want all 0", i, ram_wren[0], ram_addr[0], ram_wdata[0], if_ack[0], d_ack[0], if_rvalid[0], d_rvalid[0], busy[0]); end
    end
  endtask

  // RD_LAT=3: IF acked at T, busy T+1..T+3, rvalid at T+3, pending D acked at T+4.
  task automatic test_rd_lat3();
    do_store(2, 11'h007, 32'h12345678);
    @(negedge clk);
    if_req[2] = 1'b1; if_addr[2] = 11'h007;
    #1;
    vectors++; if (if_ack[2] !== 1'b1) begin miscompares++; $display("FAIL l3_if_ack: got %b want 1", if_ack[2]); end
    @(negedge clk);
    if_req[2] = 1'b0; d_req[2] = 1'b1; d_we[2] = 1'b0; d_addr[2] = 11'h007;
    for (int t = 1; t <= 3; t++) begin
      #1;
      vectors++; if ({busy[2], d_ack[2], if_rvalid[2]} !== {2'b10, (t == 3)}) begin miscompares++; $display("FAIL l3_T+%0d: busy/d_ack/if_rvalid got %b want %b", t, {busy[2], d_ack[2], if_rvalid[2]}, {2'b10, (t == 3)}); end
      @(negedge clk);
    end
    vectors++; if (if_rdata[2] !== 32'h0) begin miscompares++; $display("FAIL l3_rdata_after: got %h want 0", if_rdata[2]); end
    #1;
    vectors++; if ({busy[2], d_ack[2]} !== 2'b01) begin miscompares++; $display("FAIL l3_T+4_dack: got %b want 01", {busy[2], d_ack[2]}); end
    @(negedge clk);
    d_req[2] = 1'b0;
    for (int t = 1; t <= 3; t++) begin
      #1;
      vectors++; if (d_rvalid[2] !== (t == 3)) begin miscompares++; $display("FAIL l3_d_rvalid+%0d: got %b want %b", t, d_rvalid[2], (t == 3)); end
      if (t == 3) begin
        vectors++; if (d_rdata[2] !== 32'h12345678) begin miscompares++; $display("FAIL l3_d_rdata: got %h want 12345678", d_rdata[2]); end
      end
      @(negedge clk);
    end
  endtask

  // RD_LAT=2: reset one cycle after a load ack drops the read entirely.
  task automatic test_reset_mid_read();
    do_store(1, 11'h009, 32'hCAFEF00D);
    @(negedge clk);
    d_req[1] = 1'b1; d_we[1] = 1'b0; d_addr[1] = 11'h009;
    #1;
    vectors++; if (d_ack[1] !== 1'b1) begin miscompares++; $display("FAIL mr_d_ack: got %b want 1", d_ack[1]); end
    @(negedge clk);
    d_req[1] = 1'b0; rst_n = 1'b0;
    #1;
    vectors++; if ({busy[1], d_rvalid[1], ram_addr[1]} !== '0) begin miscompares++; $display("FAIL mr_in_reset: busy %b rvalid %b addr %h want 0", busy[1], d_rvalid[1], ram_addr[1]); end
    @(negedge clk);
    rst_n = 1'b1; if_req[1] = 1'b1; if_addr[1] = 11'h009;
    #1;
    vectors++; if ({d_rvalid[1], if_ack[1]} !== 2'b01) begin miscompares++; $display("FAIL mr_release: rvalid/if_ack got %b want 01", {d_rvalid[1], if_ack[1]}); end
    @(negedge clk);
    if_req[1] = 1'b0;
    #1;
    vectors++; if ({busy[1], if_rvalid[1], d_rvalid[1]} !== 3'b100) begin miscompares++; $display("FAIL mr_wait: got %b want 100", {busy[1], if_rvalid[1], d_rvalid[1]}); end
    @(negedge clk);
    #1;
    vectors++; if ({if_rvalid[1], d_rvalid[1]} !== 2'b10) begin miscompares++; $display("FAIL mr_rvalid: got %b want 10", {if_rvalid[1], d_rvalid[1]}); end
    vectors++; if (if_rdata[1] !== 32'hCAFEF00D) begin miscompares++; $display("FAIL mr_rdata: got %h want cafef00d", if_rdata[1]); end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < N; k++) begin
      if_req[k] = 1'b0; if_addr[k] = '0;
      d_req[k]  = 1'b0; d_we[k]    = 1'b0; d_addr[k] = '0; d_wdata[k] = '0;
    end
    test_reset();
    test_if_read();
    test_store_load();
    test_back_to_back();
    test_contention();
    test_idle();
    test_rd_lat3();
    test_reset_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t, want finished", $time);
    $fatal(1);
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single 32-bit RAM between two requesters: instruction fetch (IF) and load/store data (D, from LDR/STR).
- Sits between the controller/datapath and the RAM. It replaces the fixed fetch_wait/memory_wait stalls with a request/acknowledge handshake and a read-valid pulse.
- Data requests have priority over fetch. A bounded-starvation counter guarantees that fetch still makes progress.

Parameters:
- ADDR_W, 11, RAM word-address width.
- DATA_W, 32, RAM data width.
- RD_LAT, 1, cycles from RAM address issue to valid ram_rdata; legal range 1..3.
- STARVE_MAX, 4, maximum consecutive D grants while if_req is pending before IF is forced.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- if_req  in  1  fetch read request; held until if_ack.
- if_addr  in  ADDR_W  fetch address; stable while if_req is high.
- if_ack  out  1  one-cycle pulse; the fetch command was issued this cycle.
- if_rvalid  out  1  one-cycle pulse; if_rdata is valid.
- if_rdata  out  DATA_W  fetched word.
- d_req  in  1  data request; held until d_ack.
- d_we  in  1  1 = store (STR), 0 = load (LDR).
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_ack  out  1  one-cycle pulse; the data command was issued.
- d_rvalid  out  1  one-cycle pulse; d_rdata is valid (loads only).
- d_rdata  out  DATA_W  loaded word.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_wren  out  1  RAM write enable.
- ram_rdata  in  DATA_W  RAM read data, valid RD_LAT cycles after the address.
- busy  out  1  high while a read is outstanding (state RD_WAIT).

Behaviour:
- States: IDLE, RD_WAIT. Internal registers:
  - lat_cnt, 2 bits;
  - owner (IF or D);
  - streak, 0..STARVE_MAX.
- Reset (asynchronous, any cycle):
  - state = IDLE, lat_cnt = 0, streak = 0, owner = IF.
  - All outputs are 0.
  - An in-flight read is dropped; no rvalid is produced for it afterwards.
- IDLE, no request: ram_addr = 0, ram_wdata = 0, ram_wren = 0, no ack.
- IDLE, arbitration when a request is present (combinational, same cycle):
  - Winner is D if d_req && !(if_req && streak == STARVE_MAX); otherwise IF if if_req.
  - The winner's address drives ram_addr. For a D store, ram_wdata = d_wdata and ram_wren = 1.
  - The winner's ack is pulsed high in this cycle; the loser sees no ack.
- Streak update, on the clock edge after a grant:
  - D grant while if_req is high: streak + 1.
  - IF grant, or if_req low: streak = 0.
- Store (D, d_we = 1): completes at ack and produces no rvalid. Next state is IDLE, so back-to-back stores are possible, one per cycle.
- Read (IF, or D with d_we = 0): next state is RD_WAIT, with lat_cnt = RD_LAT-1 and owner = winner.
- RD_WAIT:
  - RAM outputs are all 0; no acks are issued even if requests are pending.
  - If lat_cnt != 0, decrement lat_cnt.
  - If lat_cnt == 0, pulse the owner's rvalid, drive its rdata = ram_rdata, and go to IDLE next cycle.
  - rdata outputs are 0 whenever their rvalid is low.
- Timing: a read acked in cycle T gives rvalid in cycle T+RD_LAT. Read throughput is one read per RD_LAT+1 cycles.
- Requester protocol violations are not checked: dropping req before ack, or changing the address while req is high.
- Simultaneous if_req and d_req with streak < STARVE_MAX: D wins, and IF stays pending.

Decomposition:
- Shared package ram_arb_pkg:
  - state enum (IDLE, RD_WAIT);
  - requester enum (REQ_IF, REQ_D);
  - constants for the default ADDR_W and DATA_W.
- No sub-module: a single module holding the FSM, latency counter and streak counter. The arbitration is a small combinational function inside it.

Test Plan:
- IF-only read, RD_LAT=1: if_req=1, if_addr=0x005, RAM[5]=0xE3A01001 → if_ack at T, if_rvalid and if_rdata=0xE3A01001 at T+1, busy=1 at T+1.
- Store then load: d_req, d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF → ram_wren=1 and d_ack at T, no d_rvalid. Then a load of 0x100 → d_rvalid with 0xDEADBEEF RD_LAT cycles after its ack.
- Contention: if_req and d_req both held high, all D loads, RD_LAT=1, STARVE_MAX=4 → four D grants, then an IF grant on the 5th arbitration, streak back to 0.
- RD_LAT=3: IF read acked at T → busy for T+1..T+3, if_rvalid only at T+3, and a d_req pending during that window is not acked before T+4.
- Reset mid-read: D load acked, rst_n low at T+1 (RD_LAT=2) → all outputs 0 immediately, no d_rvalid after release, and the next request is acked in the first cycle after reset release.
- Idle: no requests for 10 cycles → ram_wren=0, ram_addr=0, all acks and rvalids 0.
